// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared widths, state encoding and port indices for dmem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int N_ADDR_DEF = 8;
  localparam int N_BIT_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_rr_pick.sv
// ============================================================================
// Module   : dmem_rr_pick
// Purpose  : 2-way picker. Round-robin on ties, or port 1 strict priority
//            when DMEM_ARB_FIXED_PRI_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic winner_o,
  output logic any_o
);

  assign any_o = req0_i | req1_i;

`ifdef DMEM_ARB_FIXED_PRI_EN
  logic unused_last;
  assign unused_last = last_owner_i;
  assign winner_o    = req1_i ? PORT_DBG : PORT_CORE;
`else
  // On a tie the port that did not own the memory last time wins.
  always_comb begin
    if (req0_i && req1_i) begin
      winner_o = ~last_owner_i;
    end else begin
      winner_o = req1_i ? PORT_DBG : PORT_CORE;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter/sequencer in front of a single-port data memory.
//            Optional macro DMEM_ARB_FIXED_PRI_EN gives port 1 strict priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_ADDR = N_ADDR_DEF,
  parameter int N_BIT  = N_BIT_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [N_ADDR-1:0] Addr0,
  input  logic [N_ADDR-1:0] Addr1,
  input  logic [N_BIT-1:0]  Wdata0,
  input  logic [N_BIT-1:0]  Wdata1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Rvalid0,
  output logic              Rvalid1,
  output logic [N_BIT-1:0]  Rdata,
  output logic [N_ADDR-1:0] Mem_Addr,
  output logic [N_BIT-1:0]  Mem_Wr_data,
  output logic              Mem_MemWrite,
  output logic              Mem_MemRead,
  input  logic [N_BIT-1:0]  Mem_Rd_data
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [N_ADDR-1:0]   addr_q, addr_d;
  logic [N_BIT-1:0]    wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [N_BIT-1:0]    rdata_q, rdata_d;
  logic                last_owner;
  logic                winner;
  logic                any_req;

`ifdef DMEM_ARB_FIXED_PRI_EN
  assign last_owner = PORT_CORE;
`else
  logic last_owner_q, last_owner_d;
  assign last_owner = last_owner_q;
`endif

  dmem_rr_pick u_pick (
    .req0_i       (Req0),
    .req1_i       (Req1),
    .last_owner_i (last_owner),
    .winner_o     (winner),
    .any_o        (any_req)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= PORT_CORE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
`ifndef DMEM_ARB_FIXED_PRI_EN
      last_owner_q <= PORT_DBG;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata_q      <= rdata_d;
`ifndef DMEM_ARB_FIXED_PRI_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata_d      = rdata_q;
`ifndef DMEM_ARB_FIXED_PRI_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          we_d    = (winner == PORT_DBG) ? We1    : We0;
          addr_d  = (winner == PORT_DBG) ? Addr1  : Addr0;
          wdata_d = (winner == PORT_DBG) ? Wdata1 : Wdata0;
          gnt0_d  = (winner == PORT_CORE);
          gnt1_d  = (winner == PORT_DBG);
`ifndef DMEM_ARB_FIXED_PRI_EN
          last_owner_d = winner;
`endif
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        // Read data lands in Rdata as the valid pulse starts next cycle.
        rdata_d   = Mem_Rd_data;
        rvalid0_d = (owner_q == PORT_CORE);
        rvalid1_d = (owner_q == PORT_DBG);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Gnt0         = gnt0_q;
  assign Gnt1         = gnt1_q;
  assign Rvalid0      = rvalid0_q;
  assign Rvalid1      = rvalid1_q;
  assign Rdata        = rdata_q;
  assign Mem_Addr     = addr_q;
  assign Mem_Wr_data  = wdata_q;
  assign Mem_MemWrite = (state_q == ST_ACCESS) && we_q;
  assign Mem_MemRead  = ((state_q == ST_ACCESS) && !we_q) || (state_q == ST_RESP);

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 256x32 data memory.
- Requester 0 is the core load/store unit. Requester 1 is the debug/DMA loader.
- Serialises their requests onto the memory's Addr/Wr_data/MemWrite/MemRead strobes and returns read data with a valid pulse.
- Round-robin fairness by default.

Parameters:
- N_ADDR, 8, address bits (memory depth 2**N_ADDR words)
- N_BIT, 32, data word width

Ports:
- Clk  input  1  single clock; all state updates on posedge Clk
- Rst  input  1  asynchronous, active-low reset
- Req0, Req1  input  1  access request; held high until Gnt seen
- We0, We1  input  1  1 = write, 0 = read; sampled with Req
- Addr0, Addr1  input  N_ADDR  word address
- Wdata0, Wdata1  input  N_BIT  write data
- Gnt0, Gnt1  output  1  one-cycle pulse: request latched, requester may drop/change Req
- Rvalid0, Rvalid1  output  1  one-cycle pulse: Rdata valid for that port
- Rdata  output  N_BIT  read data, shared bus, qualified by Rvalid0/1
- Mem_Addr  output  N_ADDR  to memory Addr
- Mem_Wr_data  output  N_BIT  to memory Wr_data
- Mem_MemWrite  output  1  to memory MemWrite
- Mem_MemRead  output  1  to memory MemRead
- Mem_Rd_data  input  N_BIT  from memory Rd_data

Behaviour:
- Reset (Rst low, asynchronous):
  - state=IDLE; all outputs 0; Mem_* = 0; Rdata=0.
  - last_owner=1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No Req: stay in IDLE.
  - Any Req: pick the winner, latch its We/Addr/Wdata into internal registers, pulse Gnt of the winner, go to ACCESS.
- Arbitration:
  - A single requester wins.
  - When both request, the winner is the port that is not last_owner. last_owner updates on grant.
- ACCESS (one cycle):
  - Mem_Addr/Mem_Wr_data are driven from the latched registers.
  - Write: Mem_MemWrite=1, Mem_MemRead=0; the memory commits at the ACCESS posedge; next state IDLE.
  - Read: Mem_MemRead=1, Mem_MemWrite=0; next state RESP.
- RESP (one cycle):
  - Mem_MemRead stays 1.
  - Mem_Rd_data is captured into Rdata at the end of RESP.
  - Rvalid of the owner pulses in the following IDLE cycle. Rdata holds until the next read capture.
- Latency from Req high in IDLE:
  - Gnt: next cycle.
  - Write committed: 2 edges.
  - Rvalid: 4th cycle.
- Throughput: write 2 cycles/access, read 3 cycles/access.
- Boundary conditions:
  - Gnt and Rvalid never both high for one port in the same cycle.
  - Mem_MemWrite and Mem_MemRead are never both high.
  - Req high outside IDLE is ignored until IDLE; no request is lost while held.
  - Req dropped before Gnt: the request is withdrawn and never serviced.
  - A new Req from the same port in the IDLE cycle carrying its Rvalid is legal and arbitrated normally.
  - Reset mid-ACCESS/RESP: the transaction is abandoned, no Rvalid, strobes drop immediately. A write in ACCESS may or may not have committed; software must rewrite.
  - Address wraps naturally within N_ADDR bits; no range check.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRI_EN.
- Defined: port 1 (debug/DMA) has strict priority and wins every tie; last_owner is unused and removed.
- Undefined: round-robin as above.
- Timing and all other behaviour are identical in both builds.

Decomposition:
- Shared package dmem_pkg holds:
  - N_ADDR/N_BIT defaults
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - port index constants PORT_CORE=1'b0, PORT_DBG=1'b1
- One natural sub-module: dmem_rr_pick (2-way round-robin/priority picker: Req0, Req1, last_owner -> winner, any).
- FSM and datapath registers stay in dmem_arbiter.

Test Plan:
- Port 0 write 32'h2453e to 8'h09 -> Gnt0 next cycle; one ACCESS cycle with Mem_MemWrite=1, Mem_Addr=8'h09; the memory word then reads 32'h2453e.
- Port 1 read of 8'h09 after the above -> Gnt1; Mem_MemRead high for 2 cycles; Rvalid1 pulse with Rdata=32'h2453e; Rvalid0 stays 0.
- Both request in the same cycle, repeated 4 times, port 0 writing 32'h1453e to 8'h10 and port 1 reading 8'h10:
  - Round-robin build: grants alternate 0,1,0,1.
  - DMEM_ARB_FIXED_PRI_EN build: port 1 always first.
- Req0 held during a port 1 read -> Req0 is serviced in the IDLE immediately after the port 1 RESP; no strobe overlap.
- Rst driven low during RESP of a read -> Mem_* and Rvalid go 0 asynchronously, state=IDLE after release; no Rvalid ever issued for the aborted read.
- Req1 pulsed for one cycle while FSM is in ACCESS, then dropped -> never granted; no memory access to its address.
